// File: rtl/mdu_pkg.sv
// Shared types for the MDU multiply writeback path: funct3 codes, the issue tag
// and the result FIFO entry.
package mdu_pkg;

   localparam int unsigned MDU_XLEN = 32;
   localparam int unsigned RD_W     = 5;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011
   } mdu_funct3_e;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mdu_mul_op_e;

   typedef struct packed {
      mdu_mul_op_e     op;
      logic [RD_W-1:0] rd;
      logic            s1;
      logic            s2;
   } mdu_tag_t;

   typedef struct packed {
      logic [MDU_XLEN-1:0] data;
      logic [RD_W-1:0]     rd;
   } mdu_entry_t;

   // Divide operations occupy the upper half of the funct3 space.
   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // Whether the magnitude product must be two's-complement negated.
   function automatic logic mul_negate(input mdu_tag_t tag);
      logic neg;
      case (tag.op)
         OP_MUL, OP_MULH: neg = tag.s1 ^ tag.s2;
         OP_MULHSU:       neg = tag.s1;
         default:         neg = 1'b0;
      endcase
      return neg;
   endfunction

endpackage

// File: rtl/mdu_sync_fifo.sv
// Small synchronous FIFO with registered storage; head is read straight from
// the storage registers so it is stable while stalled.
module mdu_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o))
      else $error("fifo overflow");
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o))
      else $error("fifo underflow");

endmodule

// File: rtl/mdu_mul_writeback.sv
// Multiply writeback stage: latches the issue tag, sign-corrects and word-selects
// the magnitude product, and queues results toward CPU writeback.
module mdu_mul_writeback
   import mdu_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = MDU_XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mdu_in_valid,
   input  logic              mdu_busy,
   input  logic [2:0]        funct3,
   input  logic [RD_W-1:0]   rd,
   input  logic              rs1_sign,
   input  logic              rs2_sign,
   input  logic [2*XLEN-1:0] mul_prod,
   input  logic              mdu_out_valid,
   output logic              cpu_busy,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [XLEN-1:0]   wb_data,
   output logic [RD_W-1:0]   wb_rd
);

   localparam int unsigned PW2 = 2 * XLEN;
   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned EW  = $bits(mdu_entry_t);

   mdu_tag_t          tag_q, tag_d;
   logic              issue;
   logic              neg;
   logic [PW2-1:0]    prod_fmt;
   mdu_entry_t        push_entry;
   mdu_entry_t        head_entry;
   logic [EW-1:0]     fifo_rdata;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign issue = mdu_in_valid && !mdu_busy && !is_div(funct3);

   // Tag is only replaced by a multiply issue; divides leave it untouched.
   always_comb begin
      tag_d = tag_q;
      if (issue) begin
         tag_d.op = mdu_mul_op_e'(funct3[1:0]);
         tag_d.rd = rd;
         tag_d.s1 = rs1_sign;
         tag_d.s2 = rs2_sign;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign neg = mul_negate(tag_q);

   always_comb begin
      prod_fmt        = neg ? (~mul_prod + PW2'(1)) : mul_prod;
      push_entry.rd   = tag_q.rd;
      push_entry.data = (tag_q.op == OP_MUL) ? prod_fmt[XLEN-1:0] : prod_fmt[PW2-1:XLEN];
   end

   // Backpressure comes from registered occupancy only, so a pop never frees a
   // slot for a push in the same cycle.
   assign fifo_push = mdu_out_valid && !cpu_busy;
   assign fifo_pop  = wb_valid && wb_ready;

   mdu_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_entry = mdu_entry_t'(fifo_rdata);
   assign cpu_busy   = fifo_full;
   assign wb_valid   = !fifo_empty;
   assign wb_data    = head_entry.data;
   assign wb_rd      = head_entry.rd;

   a_count_range: assert property (@(posedge clk) disable iff (!rst) fifo_count <= CW'(DEPTH))
      else $error("fifo count out of range");

endmodule

// File: tb/tb_mdu_mul_writeback.sv
// Bench for mdu_mul_writeback: directed opcode vectors, backpressure, divide
// isolation, randomized traffic against a queue model, and reset mid-stream.
module tb_mdu_mul_writeback;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic              clk;
   logic              rst;
   logic              mdu_in_valid;
   logic              mdu_busy;
   logic [2:0]        funct3;
   logic [4:0]        rd;
   logic              rs1_sign;
   logic              rs2_sign;
   logic [2*XLEN-1:0] mul_prod;
   logic              mdu_out_valid;
   logic              cpu_busy;
   logic              wb_valid;
   logic              wb_ready;
   logic [XLEN-1:0]   wb_data;
   logic [4:0]        wb_rd;

   mdu_mul_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .mdu_in_valid  (mdu_in_valid),
      .mdu_busy      (mdu_busy),
      .funct3        (funct3),
      .rd            (rd),
      .rs1_sign      (rs1_sign),
      .rs2_sign      (rs2_sign),
      .mul_prod      (mul_prod),
      .mdu_out_valid (mdu_out_valid),
      .cpu_busy      (cpu_busy),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
   } ref_t;

   ref_t        mq[$];
   logic [1:0]  m_op;
   logic [4:0]  m_rd;
   logic        m_s1, m_s2;
   int          n_checks;
   int          n_fail;

   // Result as the ISA defines it: signed product, then low or high word.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic s1,
                                              input logic s2, input logic [63:0] prod);
      logic        neg;
      logic [63:0] p;
      neg = (op == 2'b11) ? 1'b0 : (op == 2'b10) ? s1 : (s1 ^ s2);
      p   = neg ? (64'd0 - prod) : prod;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // One clock: model sees the same inputs as the DUT, state updates after the edge.
   task automatic step();
      bit         push, pop, iss;
      ref_t       e;
      logic [2:0] f3;
      logic [4:0] r;
      logic       a, b;
      push = mdu_out_valid && (mq.size() < DEPTH);
      pop  = wb_ready && (mq.size() > 0);
      iss  = mdu_in_valid && !mdu_busy && !funct3[2];
      f3 = funct3; r = rd; a = rs1_sign; b = rs2_sign;
      e.data = ref_result(m_op, m_s1, m_s2, mul_prod);
      e.rd   = m_rd;
      @(posedge clk); #1;
      if (pop) mq.delete(0);
      if (push) mq.push_back(e);
      if (iss) begin
         m_op = f3[1:0]; m_rd = r; m_s1 = a; m_s2 = b;
      end
   endtask

   task automatic do_issue(input logic [2:0] f3, input logic [4:0] r, input logic a, input logic b);
      funct3 = f3; rd = r; rs1_sign = a; rs2_sign = b; mdu_in_valid = 1'b1;
      step();
      mdu_in_valid = 1'b0;
   endtask

   task automatic do_complete(input logic [63:0] p);
      mul_prod = p; mdu_out_valid = 1'b1;
      step();
      mdu_out_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_busy got %b want 0", cpu_busy); end
      n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
      n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
      rst = 1'b1;
      step();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", wb_valid); end
   endtask

   task automatic test_directed_ops();
      logic [2:0]  f3_t  [4];
      logic [4:0]  rd_t  [4];
      logic        s1_t  [4];
      logic        s2_t  [4];
      logic [63:0] pr_t  [4];
      logic [31:0] ex_t  [4];
      f3_t = '{3'b000, 3'b001, 3'b010, 3'b011};
      rd_t = '{5'd5, 5'd10, 5'd11, 5'd12};
      s1_t = '{1'b1, 1'b1, 1'b1, 1'b1};
      s2_t = '{1'b0, 1'b1, 1'b1, 1'b1};
      pr_t = '{64'h0000_0000_0000_0006, 64'h0000_0001_0000_0000,
               64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001};
      ex_t = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_issue(f3_t[i], rd_t[i], s1_t[i], s2_t[i]);
         n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_valid_before_push got %b want 0", i, wb_valid); end
         do_complete(pr_t[i]);
         n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_valid got %b want 1", i, wb_valid); end
         n_checks++; if (wb_data !== ex_t[i]) begin n_fail++; $display("FAIL op%0d_data got %h want %h", i, wb_data, ex_t[i]); end
         n_checks++; if (wb_rd !== rd_t[i]) begin n_fail++; $display("FAIL op%0d_rd got %0d want %0d", i, wb_rd, rd_t[i]); end
         wb_ready = 1'b1;
         step();
         wb_ready = 1'b0;
         n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_drained got %b want 0", i, wb_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [4:0]  exp_rd [2];
      logic [31:0] exp_dt [2];
      exp_rd = '{5'd2, 5'd3};
      exp_dt = '{32'd4, 32'd9};
      wb_ready = 1'b0;
      do_issue(3'b000, 5'd1, 1'b0, 1'b0);
      do_complete(64'd3);
      do_issue(3'b000, 5'd2, 1'b1, 1'b1);
      do_complete(64'd4);
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL bp_full got %b want 1", cpu_busy); end
      do_issue(3'b011, 5'd3, 1'b0, 1'b0);
      mul_prod = 64'h0000_0009_0000_0000;
      mdu_out_valid = 1'b1;
      step();
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL bp_held got %b want 1", cpu_busy); end
      n_checks++; if (wb_rd !== 5'd1) begin n_fail++; $display("FAIL bp_stall_rd got %0d want 1", wb_rd); end
      n_checks++; if (wb_data !== 32'd3) begin n_fail++; $display("FAIL bp_stall_data got %h want 3", wb_data); end
      wb_ready = 1'b1;
      #1;
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_during_pop got %b want 1", cpu_busy); end
      step();
      wb_ready = 1'b0;
      n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after_pop got %b want 0", cpu_busy); end
      n_checks++; if (wb_rd !== 5'd2) begin n_fail++; $display("FAIL bp_head_after_pop got %0d want 2", wb_rd); end
      step();
      mdu_out_valid = 1'b0;
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL bp_third_push got %b want 1", cpu_busy); end
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL drain%0d_valid got %b want 1", i, wb_valid); end
         n_checks++; if (wb_rd !== exp_rd[i]) begin n_fail++; $display("FAIL drain%0d_rd got %0d want %0d", i, wb_rd, exp_rd[i]); end
         n_checks++; if (wb_data !== exp_dt[i]) begin n_fail++; $display("FAIL drain%0d_data got %h want %h", i, wb_data, exp_dt[i]); end
         wb_ready = 1'b1;
         step();
         wb_ready = 1'b0;
      end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", wb_valid); end
   endtask

   task automatic test_divide_isolation();
      wb_ready = 1'b0;
      do_issue(3'b000, 5'd7, 1'b0, 1'b0);
      do_issue(3'b100, 5'd9, 1'b1, 1'b1);
      mdu_busy = 1'b1;
      do_issue(3'b001, 5'd13, 1'b1, 1'b0);
      mdu_busy = 1'b0;
      do_complete(64'h0000_0000_0000_000A);
      n_checks++; if (wb_rd !== 5'd7) begin n_fail++; $display("FAIL div_iso_rd got %0d want 7", wb_rd); end
      n_checks++; if (wb_data !== 32'h0000_000A) begin n_fail++; $display("FAIL div_iso_data got %h want a", wb_data); end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         mdu_in_valid  = ($urandom_range(0, 3) == 0);
         mdu_busy      = ($urandom_range(0, 3) == 0);
         funct3        = 3'($urandom_range(0, 7));
         rd            = 5'($urandom_range(0, 31));
         rs1_sign      = 1'($urandom_range(0, 1));
         rs2_sign      = 1'($urandom_range(0, 1));
         mdu_out_valid = ($urandom_range(0, 2) == 0);
         mul_prod      = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
         wb_ready      = 1'($urandom_range(0, 1));
         n_checks++;
         if (wb_valid !== (mq.size() != 0)) begin
            n_fail++; $display("FAIL rnd%0d_valid got %b want %b", c, wb_valid, mq.size() != 0);
         end
         n_checks++;
         if (cpu_busy !== (mq.size() == DEPTH)) begin
            n_fail++; $display("FAIL rnd%0d_busy got %b want %b", c, cpu_busy, mq.size() == DEPTH);
         end
         if (mq.size() != 0) begin
            n_checks++;
            if (wb_data !== mq[0].data) begin
               n_fail++; $display("FAIL rnd%0d_data got %h want %h", c, wb_data, mq[0].data);
            end
            n_checks++;
            if (wb_rd !== mq[0].rd) begin
               n_fail++; $display("FAIL rnd%0d_rd got %0d want %0d", c, wb_rd, mq[0].rd);
            end
         end
         step();
      end
      mdu_in_valid = 1'b0; mdu_busy = 1'b0; mdu_out_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      wb_ready = 1'b1;
      repeat (3) step();
      wb_ready = 1'b0;
      do_issue(3'b000, 5'd4, 1'b1, 1'b0);
      do_complete(64'd5);
      do_complete(64'd6);
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL mid_full got %b want 1", cpu_busy); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", wb_valid); end
      n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", cpu_busy); end
      n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", wb_data); end
      mq.delete();
      m_op = 2'b00; m_rd = 5'd0; m_s1 = 1'b0; m_s2 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      wb_ready = 1'b1;
      step();
      step();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_empty got %b want 0", wb_valid); end
      wb_ready = 1'b0;
      do_complete(64'hFFFF_FFFF_1234_5678);
      n_checks++; if (wb_data !== 32'h1234_5678) begin n_fail++; $display("FAIL tag_cleared_data got %h want 12345678", wb_data); end
      n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL tag_cleared_rd got %0d want 0", wb_rd); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      mdu_in_valid = 1'b0; mdu_busy = 1'b0; funct3 = 3'b000; rd = 5'd0;
      rs1_sign = 1'b0; rs2_sign = 1'b0; mul_prod = 64'd0; mdu_out_valid = 1'b0;
      wb_ready = 1'b0;
      m_op = 2'b00; m_rd = 5'd0; m_s1 = 1'b0; m_s2 = 1'b0;
      test_reset();
      test_directed_ops();
      test_backpressure();
      test_divide_isolation();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
